sprite_load_ctrl: RTL and testbench

Controller for the write port of a 32x32 car sprite RAM (1024 words, CD-bit colour). It streams one animation frame from a multi-frame sprite ROM into the sprite RAM during vertical blanking, and only when the requested frame differs from the frame already loaded. It also arbitrates the same write port with a host (CPU bus) writer. The block sits between the video sync/frame logic, the sprite frame ROM and the sprite source's `we/addr_w/pixel_in` inputs.

---
 rtl/sprite_load_ctrl.sv | 156 +++++++++++++++
 tb/tb_sprite_load_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_load_ctrl.sv
// Sprite RAM write-port controller: streams one ROM frame in vblank
// and shares the write port with a host writer while idle.
module sprite_load_ctrl #(
    parameter int CD   = 12,
    parameter int ADDR = 10,
    parameter int FW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vblank_start,
    input  logic [FW-1:0]      frame_sel,
    input  logic               reload,
    input  logic               host_we,
    input  logic [ADDR-1:0]    host_addr,
    input  logic [CD-1:0]      host_data,
    output logic               host_ready,
    output logic [FW+ADDR-1:0] rom_addr,
    input  logic [CD-1:0]      rom_data,
    output logic               we,
    output logic [ADDR-1:0]    addr_w,
    output logic [CD-1:0]      pixel_in,
    output logic               busy,
    output logic               done,
    output logic [FW-1:0]      cur_frame
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR-1:0] r_cnt;
    logic [ADDR-1:0] r_a1;
    logic            r_v1;
    logic            r_drain;
    logic            r_loaded;
    logic            r_pend;
    logic [FW-1:0]   r_frame;
    logic            r_we;
    logic [ADDR-1:0] r_addr_w;
    logic [CD-1:0]   r_pixel;
    logic            r_done;
    logic [FW-1:0]   r_cur;

    logic w_start;
    logic w_drain_end;
    logic w_need;
    logic w_host_go;

    assign w_need = !r_loaded || (frame_sel != r_cur) || r_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_drain_end = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (vblank_start && w_need) begin
                    w_start = 1'b1;
                    w_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_cnt == {ADDR{1'b1}}) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_next      = S_IDLE;
                    w_drain_end = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counter, latched frame and the reload/loaded bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_frame  <= '0;
            r_drain  <= 1'b0;
            r_loaded <= 1'b0;
            r_pend   <= 1'b0;
            r_cur    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_drain <= (r_state == S_DRAIN);
            r_done  <= w_drain_end;
            if (w_start) begin
                r_frame <= frame_sel;
                r_cnt   <= '0;
            end else if (r_state == S_LOAD) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_start) begin
                r_pend <= 1'b0;
            end else if (reload) begin
                r_pend <= 1'b1;
            end
            if (w_drain_end) begin
                r_cur    <= r_frame;
                r_loaded <= 1'b1;
            end
        end
    end

    assign w_host_go = (r_state == S_IDLE) && host_we;

    // ROM data arrives one cycle after its address; v1/a1 track it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_a1     <= '0;
            r_we     <= 1'b0;
            r_addr_w <= '0;
            r_pixel  <= '0;
        end else begin
            r_v1 <= (r_state == S_LOAD);
            r_a1 <= r_cnt;
            r_we <= r_v1 || w_host_go;
            if (w_host_go) begin
                r_addr_w <= host_addr;
                r_pixel  <= host_data;
            end else begin
                r_addr_w <= r_a1;
                r_pixel  <= rom_data;
            end
        end
    end

    assign host_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign rom_addr   = {r_frame, r_cnt};
    assign we         = r_we;
    assign addr_w     = r_addr_w;
    assign pixel_in   = r_pixel;
    assign done       = r_done;
    assign cur_frame  = r_cur;

endmodule

// File: tb/tb_sprite_load_ctrl.sv
// Directed bench for sprite_load_ctrl with a ROM model and
// a write scoreboard checked on every RAM write.
module tb_sprite_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vblank_start;
    logic [1:0]  frame_sel;
    logic        reload;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [11:0] host_data;
    logic        host_ready;
    logic [11:0] rom_addr;
    logic [11:0] rom_data;
    logic        we;
    logic [9:0]  addr_w;
    logic [11:0] pixel_in;
    logic        busy;
    logic        done;
    logic [1:0]  cur_frame;

    int tests = 0;
    int fails = 0;
    logic [21:0] sb[$];

    always #5 clk = ~clk;

    sprite_load_ctrl dut (
        .clk(clk), .rst_n(rst_n), .vblank_start(vblank_start),
        .frame_sel(frame_sel), .reload(reload), .host_we(host_we),
        .host_addr(host_addr), .host_data(host_data),
        .host_ready(host_ready), .rom_addr(rom_addr),
        .rom_data(rom_data), .we(we), .addr_w(addr_w),
        .pixel_in(pixel_in), .busy(busy), .done(done),
        .cur_frame(cur_frame)
    );

    function automatic logic [11:0] rom_f(input logic [11:0] a);
        logic [11:0] m;
        m = a * 12'd7;
        return m ^ 12'h5A3;
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {addr_w, pixel_in}, 22'h0);
                if ({addr_w, pixel_in} == 22'h0)
                    chk("unexpected_write_z", 32'd1, 32'd0);
            end else begin
                chk("write", {addr_w, pixel_in}, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [1:0] f);
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] a;
            a = i[9:0];
            sb.push_back({a, rom_f({f, a})});
        end
    endtask

    task automatic load_frame(input logic [1:0] f, input bit exp_load,
                              input bit host_trig, input bit host_hold,
                              input bit midchg);
        vblank_start = 1'b1;
        frame_sel    = f;
        if (host_trig) begin
            host_we   = 1'b1;
            host_addr = 10'h2A7;
            host_data = 12'h6B1;
            sb.push_back({10'h2A7, 12'h6B1});
        end
        if (exp_load) push_frame(f);
        tick();
        vblank_start = 1'b0;
        host_we      = 1'b0;
        if (!exp_load) begin
            chk("noload_busy", busy, 0);
            chk("noload_ready", host_ready, 1);
            return;
        end
        chk("t1_busy", busy, 1);
        chk("t1_rom_addr", rom_addr, {f, 10'd0});
        chk("t1_ready", host_ready, 0);
        if (host_hold) begin
            host_we   = 1'b1;
            host_addr = 10'h155;
            host_data = 12'h3C3;
        end
        tick();
        chk("t2_we", we, 0);
        for (int i = 3; i <= 1026; i++) begin
            tick();
            if (i == 3) begin
                chk("t3_we", we, 1);
                chk("t3_addr", addr_w, 0);
            end
            if (midchg && i == 100) begin
                vblank_start = 1'b1;
                frame_sel    = 2'd3;
            end
            if (midchg && i == 101) vblank_start = 1'b0;
        end
        chk("t1026_busy", busy, 1);
        chk("t1026_ready", host_ready, 0);
        chk("t1026_done", done, 0);
        tick();
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", host_ready, 1);
        chk("cur_frame", cur_frame, f);
        chk("sb_empty", sb.size(), 0);
        chk("cnt_wrap", rom_addr, {f, 10'd0});
        if (host_hold) sb.push_back({10'h155, 12'h3C3});
        tick();
        host_we = 1'b0;
        chk("done_pulse", done, 0);
        if (host_hold) begin
            chk("host_we", we, 1);
            chk("host_addr", addr_w, 10'h155);
            chk("host_data", pixel_in, 12'h3C3);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        vblank_start = 1'b0;
        frame_sel    = 2'd0;
        reload       = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_data    = '0;
        tick();
        tick();
        chk("rst_we", we, 0);
        chk("rst_addr_w", addr_w, 0);
        chk("rst_pixel", pixel_in, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cur", cur_frame, 0);
        chk("rst_ready", host_ready, 1);
        rst_n = 1'b1;
        tick();

        load_frame(2'd2, 1, 0, 0, 0);

        host_we   = 1'b1;
        host_addr = 10'h005;
        host_data = 12'hABC;
        sb.push_back({10'h005, 12'hABC});
        load_frame(2'd2, 0, 0, 0, 0);
        chk("idle_host_we", we, 1);
        chk("idle_host_addr", addr_w, 10'h005);
        tick();
        chk("sb_host", sb.size(), 0);

        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        load_frame(2'd2, 1, 0, 0, 0);

        load_frame(2'd0, 1, 1, 1, 0);

        load_frame(2'd1, 1, 0, 0, 1);
        chk("mid_cur", cur_frame, 1);
        load_frame(2'd3, 1, 0, 0, 0);

        vblank_start = 1'b1;
        frame_sel    = 2'd0;
        push_frame(2'd0);
        tick();
        vblank_start = 1'b0;
        repeat (499) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_we", we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cur", cur_frame, 0);
        rst_n = 1'b1;
        sb.delete();
        tick();
        load_frame(2'd0, 1, 0, 0, 0);

        repeat (3) tick();
        chk("final_sb", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
